// File: rtl/logic_trainer_sweep.sv
// Gate trainer: manual W-bit bitwise gate evaluation plus an automatic sweep
// over all 8 gate codes x 4 (a,b) combinations that records a 32-bit truth table.
// Optional start debouncer is enabled by defining TRAINER_DEBOUNCE_EN.
module logic_trainer_sweep #(
    parameter int unsigned W           = 4,
    parameter int unsigned STEP_CYCLES = 4,
    parameter int unsigned DEB_CYCLES  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   sel,
    input  logic         start,
    input  logic [2:0]   tbl_sel,
    output logic [W-1:0] y,
    output logic [1:0]   sweep_ab,
    output logic         busy,
    output logic         done,
    output logic [3:0]   tbl_out
);

    localparam int unsigned PreW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Single-bit gate truth function shared by manual mode and the sweep.
    function automatic logic gate_bit(input logic [2:0] code, input logic x, input logic z);
        logic r;
        case (code)
            3'b000:  r = x & z;
            3'b001:  r = x | z;
            3'b010:  r = ~x;
            3'b011:  r = ~(x & z);
            3'b100:  r = ~(x | z);
            3'b101:  r = x ^ z;
            3'b110:  r = ~(x ^ z);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] gate_vec(input logic [2:0] code, input logic [W-1:0] x,
                                              input logic [W-1:0] z);
        logic [W-1:0] r;
        for (int i = 0; i < int'(W); i++) begin
            r[i] = gate_bit(code, x[i], z[i]);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Start conditioning
    // ------------------------------------------------------------------
    logic start_f;
    logic start_f_q;

`ifdef TRAINER_DEBOUNCE_EN
    localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            filt_q, filt_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

    // Filtered level follows the synchronised level after DEB_CYCLES stable cycles.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (deb_cnt_q == DebLast) begin
                filt_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchroniser and debounce state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            filt_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= start;
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign start_f = filt_q;
`else
    logic start_s_q;

    // DEB_CYCLES only matters when the debouncer is built in.
    logic [31:0] unused_deb_cycles;
    assign unused_deb_cycles = 32'(DEB_CYCLES);

    // Single register stage on the raw button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s_q <= 1'b0;
        end else begin
            start_s_q <= start;
        end
    end

    assign start_f = start_s_q;
`endif

    // Delayed copy of the conditioned level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_f_q <= 1'b0;
        end else begin
            start_f_q <= start_f;
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM and registered outputs
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [31:0]     tbl_q, tbl_d;
    logic [W-1:0]    y_q, y_d;
    logic [1:0]      sweep_ab_q, sweep_ab_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            start_rise;
    logic            step_bit;

    assign start_rise = start_f & ~start_f_q;

    // Next-state logic; y and sweep_ab track the step that will be held next cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pre_d      = pre_q;
        tbl_d      = tbl_q;
        busy_d     = busy_q;
        done_d     = done_q;
        y_d        = '0;
        sweep_ab_d = 2'b00;
        step_bit   = gate_bit(idx_q[4:2], idx_q[0], idx_q[1]);

        case (state_q)
            StIdle, StDone: begin
                // ena low blocks a coincident start edge.
                if (ena && start_rise) begin
                    tbl_d   = '0;
                    idx_d   = '0;
                    pre_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!ena) begin
                    // Abort keeps the partially captured table.
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (pre_q == PreLast) begin
                    tbl_d[idx_q] = step_bit;
                    pre_d        = '0;
                    if (idx_q == 5'd31) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        if (state_d == StRun) begin
            y_d[0]     = gate_bit(idx_d[4:2], idx_d[0], idx_d[1]);
            sweep_ab_d = idx_d[1:0];
        end else if (ena) begin
            y_d = gate_vec(sel, a, b);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            pre_q      <= '0;
            tbl_q      <= '0;
            y_q        <= '0;
            sweep_ab_q <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pre_q      <= pre_d;
            tbl_q      <= tbl_d;
            y_q        <= y_d;
            sweep_ab_q <= sweep_ab_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign y        = y_q;
    assign sweep_ab = sweep_ab_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tbl_out  = tbl_q[4*tbl_sel +: 4];

endmodule

// File: tb/tb_logic_trainer_sweep.sv
// Self-checking bench for logic_trainer_sweep: randomized manual and sweep stimulus
// against a behavioural model of gate results and sweep timing.
module tb_logic_trainer_sweep;

    localparam int unsigned W    = 4;
    localparam int unsigned STEP = 4;
    localparam int unsigned DEB  = 16;
`ifdef TRAINER_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] a, b;
    logic [2:0]   sel;
    logic         start;
    logic [2:0]   tbl_sel;
    logic [W-1:0] y;
    logic [1:0]   sweep_ab;
    logic         busy, done;
    logic [3:0]   tbl_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] tbl_model;

    logic_trainer_sweep #(.W(W), .STEP_CYCLES(STEP), .DEB_CYCLES(DEB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .a       (a),
        .b       (b),
        .sel     (sel),
        .start   (start),
        .tbl_sel (tbl_sel),
        .y       (y),
        .sweep_ab(sweep_ab),
        .busy    (busy),
        .done    (done),
        .tbl_out (tbl_out)
    );

    always #5 clk = ~clk;

    // Gate rules: AND, OR, NOT a, NAND, NOR, XOR, XNOR, zero.
    function automatic logic [W-1:0] ref_gate(input logic [2:0] c, input logic [W-1:0] x,
                                              input logic [W-1:0] z);
        case (c)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return ~x;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return x ^ z;
            3'd6: return ~(x ^ z);
            default: return '0;
        endcase
    endfunction

    // Result of sweep step s: gate s/4, a = s[0], b = s[1].
    function automatic logic ref_step(input int s);
        logic [W-1:0] r;
        r = ref_gate(3'(s / 4), W'(s % 2), W'((s / 2) % 2));
        return r[0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Holds start until busy rises (bounded) and checks the start-to-busy latency.
    task automatic press_start;
        int edges;
        start = 1'b1;
        edges = 0;
        while (busy !== 1'b1 && edges < 64) begin
            tick();
            edges++;
        end
        start = 1'b0;
        checks++;
        if (edges != LAT || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: got %0d edges (busy=%b), expected %0d", edges, busy, LAT);
        end
        tbl_model = '0;
    endtask

    // Advance n RUN cycles from RUN cycle c0, updating the table model on captures.
    task automatic run_cycles(input int c0, input int n);
        for (int c = c0; c < c0 + n; c++) begin
            if (c % STEP == STEP - 1) tbl_model[c / STEP] = ref_step(c / STEP);
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b0; start = 1'b0; a = '0; b = '0; sel = '0; tbl_sel = '0;
        #12;
        checks++;
        if (y !== '0 || busy !== 1'b0 || done !== 1'b0 || sweep_ab !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs: y=%h busy=%b done=%b ab=%b, expected all 0",
                     y, busy, done, sweep_ab);
        end
        for (int i = 0; i < 4; i++) begin
            tbl_sel = 3'($urandom_range(0, 7));
            #1;
            checks++;
            if (tbl_out !== 4'h0) begin
                errors++;
                $display("FAIL reset_tbl_out: sel=%0d got %h expected 0", tbl_sel, tbl_out);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_manual(input int n);
        logic [W-1:0] exp;
        // Worked example: XOR of 1100 and 1010.
        ena = 1'b1; sel = 3'b101; a = 4'b1100; b = 4'b1010;
        tick();
        checks++;
        if (y !== 4'b0110) begin
            errors++;
            $display("FAIL manual_xor_example: got %b expected 0110", y);
        end
        for (int i = 0; i < n; i++) begin
            ena = ($urandom_range(0, 3) != 0);
            sel = 3'($urandom);
            a   = W'($urandom);
            b   = W'($urandom);
            exp = ena ? ref_gate(sel, a, b) : '0;
            tick();
            checks++;
            if (y !== exp) begin
                errors++;
                $display("FAIL manual: ena=%b sel=%0d a=%h b=%h got %h expected %h",
                         ena, sel, a, b, y, exp);
            end
        end
        ena = 1'b1;
        tick();
    endtask

    task automatic test_sweep;
        int step;
        logic [W-1:0] exp_y;
        ena = 1'b1;
        press_start();
        for (int c = 0; c < 32 * STEP; c++) begin
            a = W'($urandom); b = W'($urandom); sel = 3'($urandom);
            if (c == 50) start = 1'b1;   // second press while running must be ignored
            if (c == 80) start = 1'b0;
            step  = c / STEP;
            exp_y = W'(ref_step(step));
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sweep_ab !== 2'(step % 4) || y !== exp_y) begin
                errors++;
                $display("FAIL sweep_cycle: c=%0d busy=%b done=%b ab=%b y=%h, expected 1 0 %b %h",
                         c, busy, done, sweep_ab, y, 2'(step % 4), exp_y);
            end
            if (c % STEP == STEP - 1) tbl_model[step] = ref_step(step);
            tick();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || sweep_ab !== 2'b00) begin
            errors++;
            $display("FAIL sweep_end: busy=%b done=%b ab=%b, expected 0 1 00", busy, done, sweep_ab);
        end
        for (int g = 0; g < 8; g++) begin
            tbl_sel = 3'(g);
            #1;
            checks++;
            if (tbl_out !== tbl_model[4*g +: 4]) begin
                errors++;
                $display("FAIL sweep_table: gate=%0d got %b expected %b",
                         g, tbl_out, tbl_model[4*g +: 4]);
            end
        end
    endtask

    task automatic test_abort(input int cut);
        ena = 1'b1;
        press_start();
        run_cycles(0, cut);
        ena = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== '0 || sweep_ab !== 2'b00) begin
            errors++;
            $display("FAIL abort_outputs: cut=%0d busy=%b done=%b y=%h ab=%b, expected 0",
                     cut, busy, done, y, sweep_ab);
        end
        for (int g = 0; g < 8; g++) begin
            tbl_sel = 3'(g);
            #1;
            checks++;
            if (tbl_out !== tbl_model[4*g +: 4]) begin
                errors++;
                $display("FAIL abort_table: cut=%0d gate=%0d got %b expected %b",
                         cut, g, tbl_out, tbl_model[4*g +: 4]);
            end
        end
        ena = 1'b1;
        idle(40);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ena_wins;
        bit seen;
        seen  = 1'b0;
        ena   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < LAT + 6; i++) begin
            tick();
            if (busy !== 1'b0) seen = 1'b1;
        end
        start = 1'b0;
        idle(40);
        ena = 1'b1;
        idle(4);
        checks++;
        if (seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL ena_wins: busy seen=%b now=%b, expected 0", seen, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        ena = 1'b1;
        press_start();
        run_cycles(0, 40);
        tbl_sel = 3'd1;
        #1;
        checks++;
        if (tbl_out !== tbl_model[7:4]) begin
            errors++;
            $display("FAIL midrun_table: got %b expected %b", tbl_out, tbl_model[7:4]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== '0 || busy !== 1'b0 || done !== 1'b0 || tbl_out !== 4'h0 || sweep_ab !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: y=%h busy=%b done=%b tbl=%h ab=%b, expected 0",
                     y, busy, done, tbl_out, sweep_ab);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

`ifdef TRAINER_DEBOUNCE_EN
    task automatic test_debounce;
        bit seen;
        int edges;
        ena   = 1'b1;
        seen  = 1'b0;
        start = 1'b1;
        idle(10);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL debounce_glitch: busy=1 after 10-cycle glitch, expected 0");
        end
        start = 1'b1;
        edges = 0;
        while (busy !== 1'b1 && edges < 64) begin
            tick();
            edges++;
            if (edges == 20) start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (edges != DEB + 3) begin
            errors++;
            $display("FAIL debounce_press: busy after %0d edges, expected %0d", edges, DEB + 3);
        end
        ena = 1'b0;
        tick();
        ena = 1'b1;
        idle(40);
    endtask
`endif

    initial begin
        test_reset();
        test_manual(24);
        test_sweep();
        test_manual(12);
        test_abort(40);
        test_abort($urandom_range(1, 127));
        test_ena_wins();
        test_reset_mid_run();
`ifdef TRAINER_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
